lamp_fpu_addsub_round_pack: RTL

// - Downstream stage of the bf16 add/sub datapath. Consumes the post-normalised {s, e, f+GRS} result and its flags.
// - Applies IEEE-754 rounding in one of five modes and packs a 16-bit bf16 word.
// - Raises the OF/UF/NX exception flags.
// - Registered output behind a valid/ready handshake; a 1-entry skid buffer keeps in_ready_o a flop output.

---
 rtl/lampFPU_pkg.sv | 61 ++++++
 rtl/lamp_fpu_round_core.sv | 92 +++++++++
 rtl/lamp_fpu_addsub_round_pack.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lampFPU_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lampFPU_pkg
//  Description : Shared types, widths and helpers for the lamp bf16 FPU
//                add/sub round-and-pack stage.
//                - LAMP_FLOAT_E_DW / LAMP_FLOAT_F_DW : bf16 field widths
//                - rnd_mode_t      : RISC-V frm rounding-mode encoding
//                - fpu_flags_t     : {of, uf, nx} exception flags
//                - skid_state_t    : output skid-buffer occupancy
//                - FUNC_roundIncrement : round-up decision for one beat
//  Revision    : 1.0 - initial release
// ============================================================================
package lampFPU_pkg;

    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rnd_mode_t;

    typedef struct packed {
        logic of;
        logic uf;
        logic nx;
    } fpu_flags_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_FULL1 = 2'd1,
        SKID_FULL2 = 2'd2
    } skid_state_t;

    // Decides whether the truncated magnitude must be bumped by one ulp.
    // Unassigned frm encodings (101..111) fall back to round-to-nearest-even.
    function automatic logic FUNC_roundIncrement(
        input logic [2:0] mode,
        input logic       s,
        input logic       lsb,
        input logic       g,
        input logic       rs
    );
        logic nx;
        logic inc;
        nx = g | rs;
        case (mode)
            RTZ:     inc = 1'b0;
            RDN:     inc = nx & s;
            RUP:     inc = nx & ~s;
            RMM:     inc = g;
            default: inc = g & (rs | lsb);
        endcase
        return inc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lamp_fpu_round_core.sv
`default_nettype none
// ============================================================================
//  Module      : lamp_fpu_round_core
//  Description : Combinational rounding and packing of one post-normalised
//                add/sub result into a bf16 word plus exception flags.
//  Ports       : s_i, e_i, f_i          sign, biased exponent, {ovf,hidden,frac,G,R,S}
//                is_overflow_i          upstream overflow
//                is_underflow_i         upstream underflow
//                is_to_round_i          0 = special value, pass through unrounded
//                rnd_mode_i             frm rounding mode
//                res_o                  packed {s, e, frac}
//                flags_o                {of, uf, nx}
//  Revision    : 1.0 - initial release
// ============================================================================
module lamp_fpu_round_core
    import lampFPU_pkg::*;
#(
    parameter int E_DW = LAMP_FLOAT_E_DW,
    parameter int F_DW = LAMP_FLOAT_F_DW
) (
    input  logic                 s_i,
    input  logic [E_DW-1:0]      e_i,
    input  logic [F_DW+4:0]      f_i,
    input  logic                 is_overflow_i,
    input  logic                 is_underflow_i,
    input  logic                 is_to_round_i,
    input  logic [2:0]           rnd_mode_i,
    output logic [E_DW+F_DW:0]   res_o,
    output fpu_flags_t           flags_o
);

    localparam int W = E_DW + F_DW;

    localparam logic [W-1:0] C_INF_MAG = {{E_DW{1'b1}}, {F_DW{1'b0}}};
    localparam logic [W-1:0] C_MAX_MAG = {{(E_DW-1){1'b1}}, 1'b0, {F_DW{1'b1}}};

    logic [F_DW-1:0] w_m;
    logic            w_g;
    logic            w_rs;
    logic            w_lsb;
    logic            w_nx;
    logic            w_inc;
    logic [W:0]      w_sum;
    logic            w_of;
    logic [W-1:0]    w_ovf_mag;
    logic [1:0]      w_unused_hi;

    // The ovf and hidden bits are already folded into e_i by the normaliser.
    assign w_unused_hi = f_i[F_DW+4:F_DW+3];

    assign w_m   = f_i[F_DW+2:3];
    assign w_g   = f_i[2];
    assign w_rs  = f_i[1] | f_i[0];
    assign w_lsb = f_i[3];
    assign w_nx  = w_g | w_rs;

    assign w_inc = FUNC_roundIncrement(rnd_mode_i, s_i, w_lsb, w_g, w_rs);

    // Single adder over {e, m}: a fraction carry ripples into the exponent,
    // which also promotes a denormal that rounds up to e = 1.
    assign w_sum = {1'b0, e_i, w_m} + {{W{1'b0}}, w_inc};

    assign w_of  = is_overflow_i | w_sum[W] | (&w_sum[W-1:F_DW]);

    // Saturation target on overflow depends on the direction of rounding.
    always_comb begin
        w_ovf_mag = C_INF_MAG;
        case (rnd_mode_i)
            RTZ:     w_ovf_mag = C_MAX_MAG;
            RDN:     w_ovf_mag = s_i ? C_INF_MAG : C_MAX_MAG;
            RUP:     w_ovf_mag = s_i ? C_MAX_MAG : C_INF_MAG;
            default: w_ovf_mag = C_INF_MAG;
        endcase
    end

    always_comb begin
        res_o   = {s_i, e_i, w_m};
        flags_o = '0;
        if (is_to_round_i) begin
            flags_o.of = w_of;
            flags_o.nx = w_nx | w_of;
            flags_o.uf = is_underflow_i | ((e_i == '0) & w_nx);
            if (w_of) begin
                res_o = {s_i, w_ovf_mag};
            end else begin
                res_o = {s_i, w_sum[W-1:0]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lamp_fpu_addsub_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : lamp_fpu_addsub_round_pack
//  Description : Final add/sub stage: rounds and packs the normalised result
//                and presents it behind a registered valid/ready handshake.
//                A one-entry skid buffer keeps in_ready_o a flop output while
//                sustaining one beat per cycle.
//  Ports       : clk, rst_n               clock, async active-low reset
//                valid_i / in_ready_o     input handshake
//                s_res_i, e_res_i, f_res_i, isOverflow_i, isUnderflow_i,
//                isToRound_i, rnd_mode_i  input beat
//                valid_o / ready_i        output handshake
//                res_o, flag_of_o, flag_uf_o, flag_nx_o  output beat
//  Revision    : 1.0 - initial release
// ============================================================================
module lamp_fpu_addsub_round_pack
    import lampFPU_pkg::*;
#(
    parameter int E_DW = LAMP_FLOAT_E_DW,
    parameter int F_DW = LAMP_FLOAT_F_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    output logic                 in_ready_o,
    input  logic                 s_res_i,
    input  logic [E_DW-1:0]      e_res_i,
    input  logic [F_DW+4:0]      f_res_i,
    input  logic                 isOverflow_i,
    input  logic                 isUnderflow_i,
    input  logic                 isToRound_i,
    input  logic [2:0]           rnd_mode_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [E_DW+F_DW:0]   res_o,
    output logic                 flag_of_o,
    output logic                 flag_uf_o,
    output logic                 flag_nx_o
);

    localparam int RW = E_DW + F_DW + 1;

    skid_state_t      state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [RW-1:0]    out_res_q;
    fpu_flags_t       out_flags_q;
    logic [RW-1:0]    skid_res_q;
    fpu_flags_t       skid_flags_q;

    logic [RW-1:0]    w_res;
    fpu_flags_t       w_flags;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // Rounding happens once, on the input side; both holding registers
    // store finished results.
    lamp_fpu_round_core #(
        .E_DW (E_DW),
        .F_DW (F_DW)
    ) u_round_core (
        .s_i            (s_res_i),
        .e_i            (e_res_i),
        .f_i            (f_res_i),
        .is_overflow_i  (isOverflow_i),
        .is_underflow_i (isUnderflow_i),
        .is_to_round_i  (isToRound_i),
        .rnd_mode_i     (rnd_mode_i),
        .res_o          (w_res),
        .flags_o        (w_flags)
    );

    assign w_in_xfer  = valid_i & in_ready_q;
    assign w_out_xfer = out_valid_q & ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SKID_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_res_q    <= '0;
            out_flags_q  <= '0;
            skid_res_q   <= '0;
            skid_flags_q <= '0;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (w_in_xfer) begin
                        out_res_q   <= w_res;
                        out_flags_q <= w_flags;
                        out_valid_q <= 1'b1;
                        state_q     <= SKID_FULL1;
                    end
                end
                SKID_FULL1: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        // Consumer stalled: park the new beat and close the input.
                        skid_res_q   <= w_res;
                        skid_flags_q <= w_flags;
                        in_ready_q   <= 1'b0;
                        state_q      <= SKID_FULL2;
                    end else if (w_out_xfer && !w_in_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= SKID_EMPTY;
                    end else if (w_in_xfer && w_out_xfer) begin
                        out_res_q   <= w_res;
                        out_flags_q <= w_flags;
                    end
                end
                SKID_FULL2: begin
                    if (w_out_xfer) begin
                        out_res_q   <= skid_res_q;
                        out_flags_q <= skid_flags_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= SKID_FULL1;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= SKID_EMPTY;
                end
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign valid_o    = out_valid_q;
    assign res_o      = out_res_q;
    assign flag_of_o  = out_flags_q.of;
    assign flag_uf_o  = out_flags_q.uf;
    assign flag_nx_o  = out_flags_q.nx;

endmodule
`default_nettype wire
